cr_ib_frame_rx: RTL and testbench

Receiver for the 64-bit inbound AXI-stream into the CCE engine, the counterpart of the bench/host-side transmitter. It accepts beats framed by tuser SoT/EoT codes, tracks frame state, classifies CQE frames (first-beat type byte 0x09), and checks tlast placement. Accepted beats are buffered in a small FIFO and presented downstream with decoded framing and error flags. It sits between the cr_cceip_64 ib_* pins and the first internal parser stage.

---
 rtl/cr_ib_frame_pkg.sv | 23 ++
 rtl/cr_ib_frame_fifo.sv | 50 +++++
 rtl/cr_ib_frame_rx.sv | 139 +++++++++++++
 tb/tb_cr_ib_frame_rx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_ib_frame_pkg.sv
// Shared types for the inbound CCE frame receiver.
// Tuser framing codes, receiver state and FIFO entry flags.
package cr_ib_frame_pkg;

   localparam logic [1:0] TUSER_SOT = 2'b01;
   localparam logic [1:0] TUSER_EOT = 2'b10;
   localparam logic [1:0] TUSER_MID = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IN_FRAME,
      ST_IN_CQE
   } rx_state_e;

   // Low bits of every FIFO entry; payload sits above these.
   typedef struct packed {
      logic sot;
      logic eot;
      logic cqe;
      logic err;
   } rx_flags_t;

endpackage

// File: rtl/cr_ib_frame_fifo.sv
// Synchronous power-of-two FIFO with full/empty/count.
// Read data is the head entry, valid whenever not empty.
module cr_ib_frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_we;
   logic             w_re;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];
   assign w_we    = i_push & ~o_full;
   assign w_re    = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_we) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_we) r_wptr <= r_wptr + 1'b1;
         if (w_re) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_we} - {{AW{1'b0}}, w_re};
      end
   end

endmodule

// File: rtl/cr_ib_frame_rx.sv
// Inbound AXI-stream frame receiver: tuser framing, CQE classify,
// tlast checking, buffered downstream with framing/error flags.
module cr_ib_frame_rx
   import cr_ib_frame_pkg::*;
#(
   parameter int         DWIDTH   = 64,
   parameter int         SWIDTH   = 8,
   parameter int         UWIDTH   = 8,
   parameter int         DEPTH    = 4,
   parameter logic [7:0] CQE_TYPE = 8'h09
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ib_tvalid,
   output logic              ib_tready,
   input  logic [DWIDTH-1:0] ib_tdata,
   input  logic [SWIDTH-1:0] ib_tstrb,
   input  logic [UWIDTH-1:0] ib_tuser,
   input  logic              ib_tlast,
   output logic              out_tvalid,
   input  logic              out_tready,
   output logic [DWIDTH-1:0] out_tdata,
   output logic [SWIDTH-1:0] out_tstrb,
   output logic              out_sot,
   output logic              out_eot,
   output logic              out_cqe,
   output logic              out_err,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       err_cnt,
   output logic              rx_idle
);

   localparam int EW = DWIDTH + SWIDTH + 4;

   rx_state_e             r_state;
   logic                  r_rdy_en;
   logic [15:0]           r_frame_cnt;
   logic [15:0]           r_err_cnt;
   logic                  w_full;
   logic                  w_empty;
   logic [$clog2(DEPTH):0] w_unused_count;
   logic                  w_unused_user;
   logic                  w_acc;
   logic                  w_sot;
   logic                  w_eot;
   logic                  w_in_frame;
   logic                  w_cqe_sot;
   logic                  w_beat_cqe;
   logic                  w_want_last;
   logic                  w_last_err;
   logic                  w_dup_sot;
   logic                  w_drop;
   logic                  w_push;
   logic                  w_err_inc;
   logic                  w_frm_inc;
   rx_flags_t             w_wflags;
   rx_flags_t             w_rflags;
   logic [EW-1:0]         w_wdata;
   logic [EW-1:0]         w_rdata;

   assign w_unused_user = ^ib_tuser[UWIDTH-1:2];

   // Ready only looks at registered state, never at out_tready.
   assign ib_tready = r_rdy_en & ~w_full;
   assign w_acc     = ib_tvalid & ib_tready;

   assign w_sot      = (ib_tuser[1:0] == TUSER_SOT);
   assign w_eot      = (ib_tuser[1:0] == TUSER_EOT);
   assign w_in_frame = (r_state != ST_IDLE);
   assign w_cqe_sot  = (ib_tdata[7:0] == CQE_TYPE);
   assign w_beat_cqe = w_sot ? w_cqe_sot : (r_state == ST_IN_CQE);

   assign w_want_last = w_eot & (r_state == ST_IN_CQE);
   assign w_last_err  = (ib_tlast != w_want_last);
   assign w_dup_sot   = w_in_frame & w_sot;
   assign w_drop      = ~w_in_frame & ~w_sot;

   assign w_push    = w_acc & ~w_drop;
   assign w_err_inc = w_acc & (w_drop | w_last_err | w_dup_sot);
   assign w_frm_inc = w_acc & w_in_frame & w_eot;

   assign w_wflags.sot = w_sot;
   assign w_wflags.eot = w_eot;
   assign w_wflags.cqe = w_beat_cqe;
   assign w_wflags.err = w_last_err | w_dup_sot;
   assign w_wdata      = {ib_tdata, ib_tstrb, w_wflags};

   cr_ib_frame_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (out_tready),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_unused_count)
   );

   // Outputs read as zero whenever nothing is presented.
   assign w_rflags   = w_rdata[3:0];
   assign out_tvalid = ~w_empty;
   assign out_tdata  = out_tvalid ? w_rdata[EW-1 -: DWIDTH] : '0;
   assign out_tstrb  = out_tvalid ? w_rdata[SWIDTH+3 -: SWIDTH] : '0;
   assign out_sot    = out_tvalid & w_rflags.sot;
   assign out_eot    = out_tvalid & w_rflags.eot;
   assign out_cqe    = out_tvalid & w_rflags.cqe;
   assign out_err    = out_tvalid & w_rflags.err;

   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;
   assign rx_idle   = (r_state == ST_IDLE) & w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rdy_en    <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_acc) begin
            unique case (1'b1)
               w_sot:   r_state <= w_cqe_sot ? ST_IN_CQE : ST_IN_FRAME;
               w_eot:   r_state <= ST_IDLE;
               default: r_state <= r_state;
            endcase
         end
         if (w_frm_inc && r_frame_cnt != 16'hFFFF)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_err_inc && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_cr_ib_frame_rx.sv
// Directed bench for cr_ib_frame_rx.
// Scenario tasks with hand-computed beats and counters.
module tb_cr_ib_frame_rx;

   logic        clk;
   logic        rst_n;
   logic        ib_tvalid;
   logic        ib_tready;
   logic [63:0] ib_tdata;
   logic [7:0]  ib_tstrb;
   logic [7:0]  ib_tuser;
   logic        ib_tlast;
   logic        out_tvalid;
   logic        out_tready;
   logic [63:0] out_tdata;
   logic [7:0]  out_tstrb;
   logic        out_sot;
   logic        out_eot;
   logic        out_cqe;
   logic        out_err;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;
   logic        rx_idle;

   int n_chk;
   int n_fail;
   int in_acc;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  s;
      logic        sot;
      logic        eot;
      logic        cqe;
      logic        err;
   } beat_t;

   beat_t q[$];

   cr_ib_frame_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ib_tvalid  (ib_tvalid),
      .ib_tready  (ib_tready),
      .ib_tdata   (ib_tdata),
      .ib_tstrb   (ib_tstrb),
      .ib_tuser   (ib_tuser),
      .ib_tlast   (ib_tlast),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tdata  (out_tdata),
      .out_tstrb  (out_tstrb),
      .out_sot    (out_sot),
      .out_eot    (out_eot),
      .out_cqe    (out_cqe),
      .out_err    (out_err),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt),
      .rx_idle    (rx_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && out_tvalid && out_tready)
         q.push_back('{out_tdata, out_tstrb, out_sot, out_eot, out_cqe, out_err});
      if (rst_n && ib_tvalid && ib_tready)
         in_acc++;
   end

   // Called and returns at posedge+1; beat is accepted on the last edge.
   task automatic send(input logic [63:0] d, input logic [7:0] u, input logic l);
      int n;
      ib_tvalid = 1'b1;
      ib_tdata  = d;
      ib_tstrb  = 8'hFF;
      ib_tuser  = u;
      ib_tlast  = l;
      n = 0;
      @(negedge clk);
      while (!ib_tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: data %h never accepted", d);
      end
      @(posedge clk); #1;
      ib_tvalid = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({ib_tready, out_tvalid, rx_idle} !== 3'b001) begin
         n_fail++;
         $display("FAIL rst_flags: got %b expected 001", {ib_tready, out_tvalid, rx_idle});
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_cnt: got %h expected 0", {frame_cnt, err_cnt});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (ib_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready_pre: got %b expected 0", ib_tready);
      end
      @(negedge clk);
      n_chk++;
      if (ib_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready_post: got %b expected 1", ib_tready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cqe();
      logic [67:0] e [5];
      e[0] = {64'h1111_2222_3333_4409, 4'b1010};
      e[1] = {64'h0000_0000_0000_00A1, 4'b0010};
      e[2] = {64'h0000_0000_0000_00A2, 4'b0010};
      e[3] = {64'h0000_0000_0000_00A3, 4'b0010};
      e[4] = {64'h0000_0000_0000_00A4, 4'b0110};
      q.delete();
      out_tready = 1'b1;
      send(64'h1111_2222_3333_4409, 8'h01, 1'b0);
      n_chk++;
      if (out_tvalid !== 1'b1 || out_tdata !== 64'h1111_2222_3333_4409) begin
         n_fail++;
         $display("FAIL cqe_latency: got %b/%h expected 1/1111222233334409", out_tvalid, out_tdata);
      end
      send(64'hA1, 8'h00, 1'b0);
      send(64'hA2, 8'hFF, 1'b0);
      send(64'hA3, 8'hFC, 1'b0);
      send(64'hA4, 8'h02, 1'b1);
      drain();
      n_chk++;
      if (q.size() != 5) begin
         n_fail++;
         $display("FAIL cqe_count: got %0d expected 5", q.size());
      end
      for (int i = 0; i < 5; i++) if (i < q.size()) begin
         n_chk++;
         if ({q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err} !== e[i]) begin
            n_fail++;
            $display("FAIL cqe_beat%0d: got %h/%b%b%b%b expected %h", i,
                     q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err, e[i]);
         end
      end
      n_chk++;
      if (q.size() > 0 && q[0].s !== 8'hFF) begin
         n_fail++;
         $display("FAIL cqe_strb: got %h expected ff", q[0].s);
      end
      n_chk++;
      if ({frame_cnt, err_cnt, rx_idle} !== {16'd1, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL cqe_cnt: got %0d/%0d/%b expected 1/0/1", frame_cnt, err_cnt, rx_idle);
      end
   endtask

   task automatic test_stats();
      logic [67:0] e [2];
      e[0] = {64'h5555_0000_0000_0008, 4'b1000};
      e[1] = {64'h5555_0000_0000_00B1, 4'b0100};
      q.delete();
      send(64'h5555_0000_0000_0008, 8'h01, 1'b0);
      send(64'h5555_0000_0000_00B1, 8'h02, 1'b0);
      drain();
      n_chk++;
      if (q.size() != 2) begin
         n_fail++;
         $display("FAIL stats_count: got %0d expected 2", q.size());
      end
      for (int i = 0; i < 2; i++) if (i < q.size()) begin
         n_chk++;
         if ({q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err} !== e[i]) begin
            n_fail++;
            $display("FAIL stats_beat%0d: got %h/%b%b%b%b expected %h", i,
                     q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err, e[i]);
         end
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== {16'd2, 16'd0}) begin
         n_fail++;
         $display("FAIL stats_cnt: got %0d/%0d expected 2/0", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_tlast();
      logic [67:0] e [5];
      e[0] = {64'hC0, 4'b1010} | {56'h0, 8'h09, 4'b0};
      e[0] = {64'h0000_0000_0000_0009, 4'b1010};
      e[1] = {64'h0000_0000_0000_00C1, 4'b0111};
      e[2] = {64'h0000_0000_0000_0008, 4'b1000};
      e[3] = {64'h0000_0000_0000_00D1, 4'b0001};
      e[4] = {64'h0000_0000_0000_00D2, 4'b0100};
      q.delete();
      send(64'h09, 8'h01, 1'b0);
      send(64'hC1, 8'h02, 1'b0);
      send(64'h08, 8'h01, 1'b0);
      send(64'hD1, 8'h00, 1'b1);
      send(64'hD2, 8'h02, 1'b0);
      drain();
      n_chk++;
      if (q.size() != 5) begin
         n_fail++;
         $display("FAIL tlast_count: got %0d expected 5", q.size());
      end
      for (int i = 0; i < 5; i++) if (i < q.size()) begin
         n_chk++;
         if ({q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err} !== e[i]) begin
            n_fail++;
            $display("FAIL tlast_beat%0d: got %h/%b%b%b%b expected %h", i,
                     q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err, e[i]);
         end
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== {16'd4, 16'd2}) begin
         n_fail++;
         $display("FAIL tlast_cnt: got %0d/%0d expected 4/2", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_orphan();
      logic [67:0] e [4];
      e[0] = {64'h0000_0000_0000_0008, 4'b1000};
      e[1] = {64'h0000_0000_0000_0009, 4'b1011};
      e[2] = {64'h0000_0000_0000_00F1, 4'b0010};
      e[3] = {64'h0000_0000_0000_00F2, 4'b0110};
      q.delete();
      send(64'hEE, 8'h02, 1'b0);
      send(64'h08, 8'h01, 1'b0);
      send(64'h09, 8'h01, 1'b0);
      send(64'hF1, 8'h03, 1'b0);
      send(64'hF2, 8'h02, 1'b1);
      drain();
      n_chk++;
      if (q.size() != 4) begin
         n_fail++;
         $display("FAIL orphan_count: got %0d expected 4", q.size());
      end
      for (int i = 0; i < 4; i++) if (i < q.size()) begin
         n_chk++;
         if ({q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err} !== e[i]) begin
            n_fail++;
            $display("FAIL orphan_beat%0d: got %h/%b%b%b%b expected %h", i,
                     q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err, e[i]);
         end
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== {16'd5, 16'd4}) begin
         n_fail++;
         $display("FAIL orphan_cnt: got %0d/%0d expected 5/4", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] d [6];
      int a0;
      int n;
      logic [63:0] d0;
      d[0] = 64'h08; d[1] = 64'h21; d[2] = 64'h22;
      d[3] = 64'h23; d[4] = 64'h24; d[5] = 64'h25;
      q.delete();
      out_tready = 1'b0;
      a0 = in_acc;
      fork
         begin
            send(d[0], 8'h01, 1'b0);
            for (int i = 1; i < 5; i++) send(d[i], 8'h00, 1'b0);
            send(d[5], 8'h02, 1'b0);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!out_tvalid && n < 20) begin
               @(negedge clk);
               n++;
            end
            d0 = out_tdata;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               n_chk++;
               if (out_tvalid !== 1'b1 || out_tdata !== d0 || out_sot !== 1'b1) begin
                  n_fail++;
                  $display("FAIL bp_stable%0d: got %b/%h expected 1/%h", i, out_tvalid, out_tdata, d0);
               end
            end
            n_chk++;
            if (d0 !== d[0]) begin
               n_fail++;
               $display("FAIL bp_head: got %h expected %h", d0, d[0]);
            end
            n_chk++;
            if (ib_tready !== 1'b0 || in_acc - a0 != 4) begin
               n_fail++;
               $display("FAIL bp_full: got ready %b acc %0d expected 0/4", ib_tready, in_acc - a0);
            end
            @(posedge clk); #1;
            out_tready = 1'b1;
         end
      join
      drain();
      n_chk++;
      if (q.size() != 6) begin
         n_fail++;
         $display("FAIL bp_count: got %0d expected 6", q.size());
      end
      for (int i = 0; i < 6; i++) if (i < q.size()) begin
         n_chk++;
         if (q[i].d !== d[i] || q[i].err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_beat%0d: got %h/%b expected %h/0", i, q[i].d, q[i].err, d[i]);
         end
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== {16'd6, 16'd4}) begin
         n_fail++;
         $display("FAIL bp_cnt: got %0d/%0d expected 6/4", frame_cnt, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [67:0] e [2];
      e[0] = {64'h0000_0000_0000_7708, 4'b1000};
      e[1] = {64'h0000_0000_0000_7701, 4'b0100};
      out_tready = 1'b0;
      send(64'h09, 8'h01, 1'b0);
      send(64'h31, 8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({out_tvalid, rx_idle, ib_tready} !== 3'b010) begin
         n_fail++;
         $display("FAIL rmid_flags: got %b expected 010", {out_tvalid, rx_idle, ib_tready});
      end
      n_chk++;
      if ({frame_cnt, err_cnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL rmid_cnt: got %h expected 0", {frame_cnt, err_cnt});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      out_tready = 1'b1;
      send(64'h7708, 8'h01, 1'b0);
      send(64'h7701, 8'h02, 1'b0);
      drain();
      n_chk++;
      if (q.size() != 2) begin
         n_fail++;
         $display("FAIL rmid_count: got %0d expected 2", q.size());
      end
      for (int i = 0; i < 2; i++) if (i < q.size()) begin
         n_chk++;
         if ({q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err} !== e[i]) begin
            n_fail++;
            $display("FAIL rmid_beat%0d: got %h/%b%b%b%b expected %h", i,
                     q[i].d, q[i].sot, q[i].eot, q[i].cqe, q[i].err, e[i]);
         end
      end
      n_chk++;
      if ({frame_cnt, err_cnt, rx_idle} !== {16'd1, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL rmid_after: got %0d/%0d/%b expected 1/0/1", frame_cnt, err_cnt, rx_idle);
      end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      in_acc     = 0;
      rst_n      = 1'b0;
      ib_tvalid  = 1'b0;
      ib_tdata   = '0;
      ib_tstrb   = '0;
      ib_tuser   = '0;
      ib_tlast   = 1'b0;
      out_tready = 1'b0;
      test_reset();
      test_cqe();
      test_stats();
      test_tlast();
      test_orphan();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
